// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Drives the execute-stage ALU operands and control signals.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [RA_W-1:0]   Rs1D,
    input  logic [RA_W-1:0]   Rs2D,
    input  logic [RA_W-1:0]   RdD,
    input  logic [CTRL_W-1:0] ALUctrlD,
    input  logic              ALUSrcD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic [1:0]        ResultSrcD,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [RA_W-1:0]   RdM,
    input  logic              RegWriteM,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [RA_W-1:0]   RdW,
    input  logic              RegWriteW,
    output logic [XLEN-1:0]   ALUop1E,
    output logic [XLEN-1:0]   ALUop2E,
    output logic [CTRL_W-1:0] ALUctrlE,
    output logic [XLEN-1:0]   WriteDataE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [RA_W-1:0]   RdE,
    output logic [RA_W-1:0]   Rs1E,
    output logic [RA_W-1:0]   Rs2E,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              ValidE,
    output logic [1:0]        ResultSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              LoadUseHazard
);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] SRC_LOAD = 2'b01;

    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic            ALUSrcE;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // Flush has priority over stall so a squashed slot never survives a hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1E       <= '0;
            RD2E       <= '0;
            ImmExtE    <= '0;
            PCE        <= '0;
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            ALUctrlE   <= '0;
            ALUSrcE    <= 1'b0;
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            BranchE    <= 1'b0;
            JumpE      <= 1'b0;
            ResultSrcE <= '0;
            ValidE     <= 1'b0;
        end else if (FlushE) begin
            RD1E       <= '0;
            RD2E       <= '0;
            ImmExtE    <= '0;
            PCE        <= '0;
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            ALUctrlE   <= '0;
            ALUSrcE    <= 1'b0;
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            BranchE    <= 1'b0;
            JumpE      <= 1'b0;
            ResultSrcE <= '0;
            ValidE     <= 1'b0;
        end else if (!StallE) begin
            RD1E       <= RD1D;
            RD2E       <= RD2D;
            ImmExtE    <= ImmExtD;
            PCE        <= PCD;
            Rs1E       <= Rs1D;
            Rs2E       <= Rs2D;
            RdE        <= RdD;
            ALUctrlE   <= ALUctrlD;
            ALUSrcE    <= ALUSrcD;
            RegWriteE  <= RegWriteD;
            MemWriteE  <= MemWriteD;
            BranchE    <= BranchD;
            JumpE      <= JumpD;
            ResultSrcE <= ResultSrcD;
            ValidE     <= ValidD;
        end
    end

    // MEM is the younger producer, so it wins over WB; x0 never forwards.
    always_comb begin
        ForwardAE = FWD_REG;
        fwd_a     = RD1E;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
            ForwardAE = FWD_MEM;
            fwd_a     = ALUResultM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
            ForwardAE = FWD_WB;
            fwd_a     = ResultW;
        end
    end

    always_comb begin
        ForwardBE = FWD_REG;
        fwd_b     = RD2E;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
            ForwardBE = FWD_MEM;
            fwd_b     = ALUResultM;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
            ForwardBE = FWD_WB;
            fwd_b     = ResultW;
        end
    end

    assign ALUop1E    = fwd_a;
    assign ALUop2E    = ALUSrcE ? ImmExtE : fwd_b;
    assign WriteDataE = fwd_b;

    assign LoadUseHazard = ValidE && (ResultSrcE == SRC_LOAD) && (RdE != '0) &&
                           ((RdE == Rs1D) || (RdE == Rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle model comparison plus hand-computed
// expectations for reset, forwarding, immediate select, stall/flush and load-use.
module tb_id_ex_stage;

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  ctrl;
        logic        alusrc, regw, memw, br, jmp, valid;
        logic [1:0]  rsrc;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    slot_t d;
    logic [31:0] alu_m = '0, res_w = '0;
    logic [4:0]  rd_m = '0, rd_w = '0;
    logic        regw_m = 1'b0, regw_w = 1'b0;

    logic [31:0] op1, op2, wdata, pc_e, imm_e;
    logic [2:0]  ctrl_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic        regw_e, memw_e, br_e, jmp_e, valid_e, luh;
    logic [1:0]  rsrc_e, fa, fb;

    int checks = 0;
    int failures = 0;
    slot_t m;  // model of the instruction currently held in E

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush), .ValidD(d.valid),
        .RD1D(d.rd1), .RD2D(d.rd2), .ImmExtD(d.imm), .PCD(d.pc),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd), .ALUctrlD(d.ctrl), .ALUSrcD(d.alusrc),
        .RegWriteD(d.regw), .MemWriteD(d.memw), .BranchD(d.br), .JumpD(d.jmp),
        .ResultSrcD(d.rsrc), .ALUResultM(alu_m), .RdM(rd_m), .RegWriteM(regw_m),
        .ResultW(res_w), .RdW(rd_w), .RegWriteW(regw_w),
        .ALUop1E(op1), .ALUop2E(op2), .ALUctrlE(ctrl_e), .WriteDataE(wdata),
        .PCE(pc_e), .ImmExtE(imm_e), .RdE(rd_e), .Rs1E(rs1_e), .Rs2E(rs2_e),
        .RegWriteE(regw_e), .MemWriteE(memw_e), .BranchE(br_e), .JumpE(jmp_e),
        .ValidE(valid_e), .ResultSrcE(rsrc_e), .ForwardAE(fa), .ForwardBE(fb),
        .LoadUseHazard(luh)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Which source a register operand is taken from: youngest writer first.
    function automatic logic [1:0] src_of(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (regw_m && rd_m == rs) return 2'b10;
        if (regw_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] val_of(input logic [4:0] rs, input logic [31:0] regval);
        logic [1:0] s;
        s = src_of(rs);
        return (s == 2'b10) ? alu_m : (s == 2'b01) ? res_w : regval;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       m <= '{default: 0};
        else if (flush)   m <= '{default: 0};
        else if (!stall)  m <= d;
    end

    always @(negedge clk) begin
        chk("m_op1", op1, val_of(m.rs1, m.rd1));
        chk("m_op2", op2, m.alusrc ? m.imm : val_of(m.rs2, m.rd2));
        chk("m_wdata", wdata, val_of(m.rs2, m.rd2));
        chk("m_fwd", {28'd0, fa, fb}, {28'd0, src_of(m.rs1), src_of(m.rs2)});
        chk("m_regs", {imm_e}, m.imm);
        chk("m_pc", pc_e, m.pc);
        chk("m_addr", {17'd0, rd_e, rs1_e, rs2_e}, {17'd0, m.rd, m.rs1, m.rs2});
        chk("m_ctrl", {21'd0, ctrl_e, regw_e, memw_e, br_e, jmp_e, valid_e, rsrc_e},
            {21'd0, m.ctrl, m.regw, m.memw, m.br, m.jmp, m.valid, m.rsrc});
        chk("m_luh", {31'd0, luh}, {31'd0, m.valid && m.rsrc == 2'b01 && m.rd != 0 &&
            (m.rd == d.rs1 || m.rd == d.rs2)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d = '{default: 0};
        step();
        #1;
        chk("reset_valid", {31'd0, valid_e}, 32'd0);
        chk("reset_op1", op1, 32'd0);
        chk("reset_luh", {31'd0, luh}, 32'd0);
        rst_n = 1'b1;

        // plain register operands
        d = '{rd1: 32'd5, rd2: 32'd7, imm: 32'd0, pc: 32'h100, rs1: 5'd1, rs2: 5'd2,
              rd: 5'd8, ctrl: 3'b001, alusrc: 1'b0, regw: 1'b1, memw: 1'b0, br: 1'b0,
              jmp: 1'b0, valid: 1'b1, rsrc: 2'b00};
        step();
        #1;
        chk("t2_op1", op1, 32'd5);
        chk("t2_op2", op2, 32'd7);
        chk("t2_ctrl", {29'd0, ctrl_e}, 32'd1);
        chk("t2_fwd", {28'd0, fa, fb}, 32'd0);
        chk("t2_pc", pc_e, 32'h100);

        // MEM beats WB, then WB alone
        d.rs1 = 5'd3; d.rd1 = 32'h99; d.pc = 32'h104;
        step();
        rd_m = 5'd3; regw_m = 1'b1; alu_m = 32'h10;
        rd_w = 5'd3; regw_w = 1'b1; res_w = 32'h20;
        #1;
        chk("t3_mem_op1", op1, 32'h10);
        chk("t3_mem_fa", {30'd0, fa}, 32'd2);
        regw_m = 1'b0;
        #1;
        chk("t3_wb_op1", op1, 32'h20);
        chk("t3_wb_fa", {30'd0, fa}, 32'd1);

        // x0 never forwards; immediate select vs store data
        d.rs1 = 5'd9; d.rs2 = 5'd0; d.rd2 = 32'h77; d.pc = 32'h108;
        rd_m = 5'd0; regw_m = 1'b1; alu_m = 32'hFF; regw_w = 1'b0;
        step();
        #1;
        chk("t4_x0_fb", {30'd0, fb}, 32'd0);
        chk("t4_x0_op2", op2, 32'h77);
        chk("t4_x0_wdata", wdata, 32'h77);
        d.alusrc = 1'b1; d.imm = 32'hFFFF_FFFC; d.rs2 = 5'd6; d.rd2 = 32'h11; d.memw = 1'b1;
        step();
        rd_w = 5'd6; regw_w = 1'b1; res_w = 32'h55;
        #1;
        chk("t4_imm_op2", op2, 32'hFFFF_FFFC);
        chk("t4_store_data", wdata, 32'h55);
        chk("t4_fb_wb", {30'd0, fb}, 32'd1);

        // stall holds E through changing D; stall+flush bubbles
        regw_m = 1'b0; regw_w = 1'b0;
        d = '{rd1: 32'h1234, rd2: 32'h5678, imm: 32'h0, pc: 32'h200, rs1: 5'd10, rs2: 5'd11,
              rd: 5'd12, ctrl: 3'b010, alusrc: 1'b0, regw: 1'b1, memw: 1'b0, br: 1'b1,
              jmp: 1'b1, valid: 1'b1, rsrc: 2'b00};
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d.rd1 = 32'hA000 + i; d.rd2 = 32'hB000 + i; d.ctrl = 3'(i); d.valid = i[0];
            d.rs1 = 5'(20 + i); d.rd = 5'(25 + i);
            step();
            #1;
            chk("t5_hold_op1", op1, 32'h1234);
            chk("t5_hold_op2", op2, 32'h5678);
            chk("t5_hold_ctrl", {21'd0, ctrl_e, regw_e, br_e, jmp_e, valid_e, rd_e},
                {21'd0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12});
        end
        flush = 1'b1; d.valid = 1'b1; d.regw = 1'b1;
        step();
        #1;
        chk("t5_flush_valid", {31'd0, valid_e}, 32'd0);
        chk("t5_flush_ctrl", {27'd0, regw_e, memw_e, br_e, jmp_e, rsrc_e != 0}, 32'd0);
        chk("t5_flush_op1", op1, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // load-use hazard
        d = '{rd1: 32'h1, rd2: 32'h2, imm: 32'h0, pc: 32'h300, rs1: 5'd1, rs2: 5'd2,
              rd: 5'd4, ctrl: 3'b000, alusrc: 1'b1, regw: 1'b1, memw: 1'b0, br: 1'b0,
              jmp: 1'b0, valid: 1'b1, rsrc: 2'b01};
        step();
        d.rs1 = 5'd1; d.rs2 = 5'd4;
        #1;
        chk("t6_luh_rs2", {31'd0, luh}, 32'd1);
        d.rs2 = 5'd5; d.rs1 = 5'd4;
        #1;
        chk("t6_luh_rs1", {31'd0, luh}, 32'd1);
        d.rs1 = 5'd7;
        #1;
        chk("t6_luh_nomatch", {31'd0, luh}, 32'd0);
        d.rd = 5'd0; d.rs1 = 5'd0; d.rs2 = 5'd0;
        step();
        #1;
        chk("t6_luh_rd0", {31'd0, luh}, 32'd0);
        d.rd = 5'd4; d.valid = 1'b0; d.rs2 = 5'd4;
        step();
        #1;
        chk("t6_luh_invalid", {31'd0, luh}, 32'd0);
        d.valid = 1'b1; d.rsrc = 2'b00;
        step();
        #1;
        chk("t6_luh_notload", {31'd0, luh}, 32'd0);

        // asynchronous reset mid-cycle with a live instruction in E
        d.rd1 = 32'hCAFE; d.rs1 = 5'd13; d.rsrc = 2'b00;
        step();
        #1;
        chk("t1_live_valid", {31'd0, valid_e}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", {31'd0, valid_e}, 32'd0);
        chk("t1_rst_regw", {31'd0, regw_e}, 32'd0);
        chk("t1_rst_op1", op1, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        #1;
        chk("t1_resume_valid", {31'd0, valid_e}, 32'd1);
        chk("t1_resume_op1", op1, 32'hCAFE);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage that sits directly upstream of the execute-stage ALU. It registers decoded operands and control, resolves operand forwarding from MEM/WB, and drives the ALU operand and control inputs. It also produces the load-use hazard flag consumed by the hazard/stall controller.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
CTRL_W, 3, ALU control width

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold all E-stage registers
FlushE  in  1  replace E-stage contents with a bubble
ValidD  in  1  decode slot holds a real instruction
RD1D, RD2D  in  XLEN  register-file read data
ImmExtD, PCD  in  XLEN  extended immediate, PC
Rs1D, Rs2D, RdD  in  RA_W  source and destination register addresses
ALUctrlD  in  CTRL_W  ALU operation
ALUSrcD  in  1  0 = reg operand B, 1 = immediate
RegWriteD, MemWriteD, BranchD, JumpD  in  1  control bits
ResultSrcD  in  2  00 = ALU, 01 = load, 10 = PC+4
ALUResultM  in  XLEN  MEM-stage ALU result
RdM  in  RA_W;  RegWriteM  in  1
ResultW  in  XLEN  WB-stage result
RdW  in  RA_W;  RegWriteW  in  1
ALUop1E, ALUop2E  out  XLEN  ALU operands
ALUctrlE  out  CTRL_W  ALU operation
WriteDataE  out  XLEN  forwarded rs2 value (store data)
PCE, ImmExtE  out  XLEN
RdE, Rs1E, Rs2E  out  RA_W
RegWriteE, MemWriteE, BranchE, JumpE, ValidE  out  1
ResultSrcE  out  2
ForwardAE, ForwardBE  out  2  00 = reg, 01 = WB, 10 = MEM
LoadUseHazard  out  1  the instruction in decode depends on a load in E

Behaviour:
- Reset: asynchronous on the falling edge of rst_n. All E registers clear to 0 immediately, so ValidE = 0 and all control bits = 0. Combinational outputs follow from the cleared registers: ALUop1E, ALUop2E and WriteDataE = 0 unless MEM/WB forwarding matches Rs1E/Rs2E = 0, which is excluded. LoadUseHazard = 0.
- Registered update on the rising edge of clk, with priority FlushE > StallE > load:
  - FlushE = 1: all registers clear to 0 (bubble). Data fields are zeroed too.
  - StallE = 1, FlushE = 0: all registers hold.
  - Otherwise: each xD input is captured into the matching xE register. ValidE <= ValidD.
- Latency D->E is 1 cycle.
- Forwarding (combinational from Rs1E/Rs2E). For operand A:
  - RegWriteM & (RdM != 0) & (RdM == Rs1E) -> ForwardAE = 10, value ALUResultM.
  - Else RegWriteW & (RdW != 0) & (RdW == Rs1E) -> 01, value ResultW.
  - Else 00, value RD1E.
  - MEM has priority over WB. Operand B is identical, using Rs2E/RD2E/ForwardBE.
- Forwarding is evaluated regardless of ValidE. Bubbles carry Rs = 0 and so never forward.
- ALUop1E = forwarded A.
- ALUop2E = ALUSrcE ? ImmExtE : forwarded B.
- WriteDataE = forwarded B, always, independent of ALUSrcE.
- ALUctrlE is passed unchanged. Encodings: 000 add, 001 sub, 010 and, 011 or, 101 slt. This block does not interpret them.
- LoadUseHazard = ValidE & (ResultSrcE == 01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
  - This block does not act on it. The controller asserts StallD and FlushE.
- Simultaneous StallE and FlushE: flush wins.
- All widths are fixed. There is no arithmetic in this block.

Test Plan:
1. rst_n low mid-run with ValidE = 1 -> outputs clear before the next edge: ValidE = 0, RegWriteE = 0, ALUop1E = 0. Release plus one load cycle -> normal capture resumes.
2. RD1D = 5, RD2D = 7, ALUSrcD = 0, ALUctrlD = 001, no forwards -> next cycle ALUop1E = 5, ALUop2E = 7, ALUctrlE = 001, ForwardAE = ForwardBE = 00.
3. Rs1E = 3 with RdM = 3/RegWriteM = 1/ALUResultM = 0x10 and RdW = 3/RegWriteW = 1/ResultW = 0x20 -> ALUop1E = 0x10, ForwardAE = 10. Drop RegWriteM -> 0x20, ForwardAE = 01.
4. Rs2E = 0, RdM = 0, RegWriteM = 1, ALUResultM = 0xFF -> no forward, ForwardBE = 00. Then ALUSrcE = 1, ImmExtE = 0xFFFFFFFC, Rs2E = 6 forwarded from WB = 0x55 -> ALUop2E = 0xFFFFFFFC, WriteDataE = 0x55.
5. StallE high 3 cycles while D inputs change -> E outputs constant. StallE and FlushE high together -> next cycle ValidE = 0, all control bits = 0.
6. Load in E (ResultSrcE = 01, RdE = 4, ValidE = 1), Rs2D = 4 -> LoadUseHazard = 1. With RdE = 0, or ValidE = 0, or ResultSrcE = 00 -> LoadUseHazard = 0.
